// File: rtl/melody_beat_sequencer_pkg.sv
// melody_beat_sequencer_pkg -- shared FSM states, tempo codes and default sizes.
// Revision 1.0
`default_nettype none
package melody_beat_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  localparam logic [1:0] TEMPO_NORMAL = 2'b00;
  localparam logic [1:0] TEMPO_FAST   = 2'b01;
  localparam logic [1:0] TEMPO_SLOW   = 2'b10;
  localparam logic [1:0] TEMPO_VFAST  = 2'b11;

  localparam int DEFAULT_SONG_LEN   = 68;
  localparam int DEFAULT_BASE_TICKS = 12_500_000;

endpackage
`default_nettype wire

// File: rtl/melody_beat_sequencer_tick.sv
// beat_tick_gen -- tick counter with tempo-latched period and beat boundary flag.
// Revision 1.0
`default_nettype none
module beat_tick_gen
  import melody_beat_sequencer_pkg::*;
#(
  parameter int BASE_TICKS = DEFAULT_BASE_TICKS
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic       clear,
  input  logic [1:0] tempo_sel,
  output logic       boundary
);

  localparam int CW = $clog2(BASE_TICKS * 2) + 1;

  logic [CW-1:0] count;
  logic [CW-1:0] period;

  function automatic logic [CW-1:0] period_for(input logic [1:0] sel);
    case (sel)
      TEMPO_FAST:  period_for = CW'(BASE_TICKS / 2);
      TEMPO_SLOW:  period_for = CW'(BASE_TICKS * 2);
      TEMPO_VFAST: period_for = CW'(BASE_TICKS / 4);
      default:     period_for = CW'(BASE_TICKS);
    endcase
  endfunction

  // Boundary is combinational so the sequencer can step beats on the same edge the counter wraps.
  assign boundary = enable && (count == period - CW'(1));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      count  <= '0;
      period <= CW'(BASE_TICKS);
    end else if (clear || boundary) begin
      count  <= '0;
      period <= period_for(tempo_sel);
    end else if (enable) begin
      count  <= count + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/melody_beat_sequencer.sv
// melody_beat_sequencer -- steps a beat index through a song with tempo, pause, stop and loop control.
// Revision 1.0
`default_nettype none
module melody_beat_sequencer
  import melody_beat_sequencer_pkg::*;
#(
  parameter int BASE_TICKS = DEFAULT_BASE_TICKS,
  parameter int SONG_LEN   = DEFAULT_SONG_LEN
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic       loop_en,
  input  logic [1:0] tempo_sel,
  output logic [7:0] beats,
  output logic       playing,
  output logic       song_done
);

  localparam logic [7:0] LAST_BEAT = 8'(SONG_LEN - 1);

  seq_state_t state;
  logic       tick_enable;
  logic       tick_clear;
  logic       boundary;

  // A pause request still counts its own cycle, so no tick is lost across pause/resume.
  assign tick_enable = (state == ST_RUN) && !stop;
  assign tick_clear  = stop || (start && ((state == ST_IDLE) || (state == ST_DONE)));

  beat_tick_gen #(
    .BASE_TICKS(BASE_TICKS)
  ) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .enable   (tick_enable),
    .clear    (tick_clear),
    .tempo_sel(tempo_sel),
    .boundary (boundary)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      beats     <= 8'd0;
      playing   <= 1'b0;
      song_done <= 1'b0;
    end else begin
      song_done <= 1'b0;
      if (stop) begin
        state   <= ST_IDLE;
        beats   <= 8'd0;
        playing <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              state   <= ST_RUN;
              beats   <= 8'd0;
              playing <= 1'b1;
            end
          end
          ST_RUN: begin
            if (boundary) begin
              if (beats == LAST_BEAT) begin
                beats     <= 8'd0;
                song_done <= 1'b1;
              end else begin
                beats <= beats + 8'd1;
              end
            end
            if (boundary && (beats == LAST_BEAT) && !loop_en) begin
              state   <= ST_DONE;
              playing <= 1'b0;
            end else if (pause) begin
              state   <= ST_PAUSE;
              playing <= 1'b0;
            end
          end
          ST_PAUSE: begin
            if (start) begin
              state   <= ST_RUN;
              playing <= 1'b1;
            end
          end
          default: begin
            state   <= ST_IDLE;
            beats   <= 8'd0;
            playing <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
